// File: rtl/trees_pkg.sv
// trees_pkg: definitions shared between the trees ensemble and its feeder.
//   - default ensemble dimensions (N_TREES_DEF, N_NODE_AND_LEAFS_DEF, N_FEATURE_DEF)
//   - index widths for the default build (N_NODE_W, N_TREE_W, FEAT_IDX_W)
//   - feeder_st_t: job sequencing states of trees_feeder
package trees_pkg;

    localparam int N_TREES_DEF          = 16;
    localparam int N_NODE_AND_LEAFS_DEF = 256;
    localparam int N_FEATURE_DEF        = 32;

    localparam int N_NODE_W   = $clog2(N_NODE_AND_LEAFS_DEF);
    localparam int N_TREE_W   = $clog2(N_TREES_DEF);
    localparam int FEAT_IDX_W = $clog2(N_FEATURE_DEF);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NODE_LO,
        ST_NODE_HI,
        ST_FEAT,
        ST_START,
        ST_WAIT,
        ST_RESULT
    } feeder_st_t;

endpackage

// File: rtl/trees_feeder.sv
// trees_feeder: front-end driver for the trees ensemble.
// A job optionally streams the whole model (word pairs packed into 64-bit
// nodes, tree-major order), then the feature vector, then pulses start,
// waits for done and offers the prediction on a valid/ready result port.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cfg_start, cfg_load_model   job request (sampled in IDLE only)
//   in_data/in_valid/in_ready   32-bit input word stream
//   load_trees, n_node, n_tree, tree_nodes   node write port to the ensemble
//   features                    packed feature vector (feature k at [32k +: 32])
//   start, done, prediction     inference handshake with the ensemble
//   result/result_valid/result_ready         prediction output handshake
//   busy                        high whenever a job is in progress
module trees_feeder
    import trees_pkg::*;
#(
    parameter int N_TREES          = N_TREES_DEF,
    parameter int N_NODE_AND_LEAFS = N_NODE_AND_LEAFS_DEF,
    parameter int N_FEATURE        = N_FEATURE_DEF,
    // The default build uses exactly the widths the ensemble is built with.
    localparam int NN_W = (N_NODE_AND_LEAFS == N_NODE_AND_LEAFS_DEF) ? N_NODE_W   : $clog2(N_NODE_AND_LEAFS),
    localparam int NT_W = (N_TREES == N_TREES_DEF)                   ? N_TREE_W   : $clog2(N_TREES),
    localparam int FI_W = (N_FEATURE == N_FEATURE_DEF)               ? FEAT_IDX_W : $clog2(N_FEATURE)
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_start,
    input  logic                      cfg_load_model,
    input  logic [31:0]               in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      load_trees,
    output logic [NN_W-1:0]           n_node,
    output logic [NT_W-1:0]           n_tree,
    output logic [63:0]               tree_nodes,
    output logic [N_FEATURE*32-1:0]   features,
    output logic                      start,
    input  logic                      done,
    input  logic [7:0]                prediction,
    output logic [7:0]                result,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic                      busy
);

    localparam logic [NN_W-1:0] LAST_NODE = NN_W'(N_NODE_AND_LEAFS - 1);
    localparam logic [NT_W-1:0] LAST_TREE = NT_W'(N_TREES - 1);
    localparam logic [FI_W-1:0] LAST_FEAT = FI_W'(N_FEATURE - 1);

    feeder_st_t      state_reg;
    logic            in_ready_reg;
    logic            load_reg;
    logic            start_reg;
    logic            result_valid_reg;
    logic            busy_reg;
    logic [NN_W-1:0] n_node_reg;
    logic [NT_W-1:0] n_tree_reg;
    logic [63:0]     tree_nodes_reg;
    logic [FI_W-1:0] feat_idx_reg;
    logic [31:0]     feat_reg [N_FEATURE];
    logic [7:0]      result_reg;

    logic accept;
    logic last_node;

    assign accept    = in_valid && in_ready_reg;
    // The address counters always describe the node being assembled: they
    // advance during the load pulse, which is at the earliest a NODE_LO cycle.
    assign last_node = (n_node_reg == LAST_NODE) && (n_tree_reg == LAST_TREE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            in_ready_reg     <= 1'b0;
            load_reg         <= 1'b0;
            start_reg        <= 1'b0;
            result_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
            n_node_reg       <= '0;
            n_tree_reg       <= '0;
            tree_nodes_reg   <= '0;
            feat_idx_reg     <= '0;
            result_reg       <= '0;
            for (int i = 0; i < N_FEATURE; i++) begin
                feat_reg[i] <= '0;
            end
        end else begin
            load_reg  <= 1'b0;
            start_reg <= 1'b0;

            // Step to the next node address once the current node is written.
            if (load_reg) begin
                if (n_node_reg == LAST_NODE) begin
                    n_node_reg <= '0;
                    n_tree_reg <= (n_tree_reg == LAST_TREE) ? '0 : n_tree_reg + 1'b1;
                end else begin
                    n_node_reg <= n_node_reg + 1'b1;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (cfg_start) begin
                        n_node_reg   <= '0;
                        n_tree_reg   <= '0;
                        feat_idx_reg <= '0;
                        busy_reg     <= 1'b1;
                        in_ready_reg <= 1'b1;
                        state_reg    <= cfg_load_model ? ST_NODE_LO : ST_FEAT;
                    end
                end
                ST_NODE_LO: begin
                    if (accept) begin
                        tree_nodes_reg[31:0] <= in_data;
                        state_reg            <= ST_NODE_HI;
                    end
                end
                ST_NODE_HI: begin
                    if (accept) begin
                        tree_nodes_reg[63:32] <= in_data;
                        load_reg              <= 1'b1;
                        state_reg             <= last_node ? ST_FEAT : ST_NODE_LO;
                    end
                end
                ST_FEAT: begin
                    if (accept) begin
                        feat_reg[feat_idx_reg] <= in_data;
                        if (feat_idx_reg == LAST_FEAT) begin
                            in_ready_reg <= 1'b0;
                            start_reg    <= 1'b1;
                            state_reg    <= ST_START;
                        end else begin
                            feat_idx_reg <= feat_idx_reg + 1'b1;
                        end
                    end
                end
                ST_START: begin
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done) begin
                        result_reg       <= prediction;
                        result_valid_reg <= 1'b1;
                        state_reg        <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (result_ready) begin
                        result_valid_reg <= 1'b0;
                        busy_reg         <= 1'b0;
                        state_reg        <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < N_FEATURE; gi++) begin : g_feat_pack
            assign features[gi*32 +: 32] = feat_reg[gi];
        end
    endgenerate

    assign in_ready     = in_ready_reg;
    assign load_trees   = load_reg;
    assign n_node       = n_node_reg;
    assign n_tree       = n_tree_reg;
    assign tree_nodes   = tree_nodes_reg;
    assign start        = start_reg;
    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_trees_feeder.sv
// tb_trees_feeder: self-checking bench for trees_feeder with a small ensemble
// (2 trees x 4 nodes, 4 features). Expected node writes are queued as node
// word pairs are driven and popped when load_trees is observed.
module tb_trees_feeder;

    localparam int T_TREES = 2;
    localparam int T_NODES = 4;
    localparam int T_FEAT  = 4;
    localparam int T_NN_W  = $clog2(T_NODES);
    localparam int T_NT_W  = $clog2(T_TREES);

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  cfg_start = 1'b0;
    logic                  cfg_load_model = 1'b0;
    logic [31:0]           in_data = '0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic                  load_trees;
    logic [T_NN_W-1:0]     n_node;
    logic [T_NT_W-1:0]     n_tree;
    logic [63:0]           tree_nodes;
    logic [T_FEAT*32-1:0]  features;
    logic                  start;
    logic                  done = 1'b0;
    logic [7:0]            prediction = '0;
    logic [7:0]            result;
    logic                  result_valid;
    logic                  result_ready = 1'b0;
    logic                  busy;

    typedef struct {
        logic [T_NT_W-1:0] tree;
        logic [T_NN_W-1:0] node;
        logic [63:0]       data;
    } node_exp_t;

    node_exp_t exp_q[$];
    int n_total = 0;
    int n_bad   = 0;

    trees_feeder #(
        .N_TREES          (T_TREES),
        .N_NODE_AND_LEAFS (T_NODES),
        .N_FEATURE        (T_FEAT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_start      (cfg_start),
        .cfg_load_model (cfg_load_model),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .load_trees     (load_trees),
        .n_node         (n_node),
        .n_tree         (n_tree),
        .tree_nodes     (tree_nodes),
        .features       (features),
        .start          (start),
        .done           (done),
        .prediction     (prediction),
        .result         (result),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete job. gap_pct randomly withholds the high node word;
    // poke injects cfg_start during WAIT and done during RESULT;
    // abort_at >= 0 returns once that many words have been accepted.
    task automatic run_job(input string name, input bit load_model, input int gap_pct,
                           input int done_delay, input int hold, input logic [7:0] pred,
                           input logic [31:0] base, input bit poke, input int abort_at);
        int node_words;
        int total_words;
        int acc;
        int cyc;
        int pulses;
        int last_pulse;
        int idx;
        bit drv;
        logic [31:0] lo_word;
        logic [31:0] word;
        logic [T_FEAT*32-1:0] feat_vec;
        node_exp_t e;

        exp_q.delete();
        node_words  = load_model ? 2 * T_TREES * T_NODES : 0;
        total_words = node_words + T_FEAT;
        acc = 0; pulses = 0; last_pulse = -1; lo_word = '0; feat_vec = '0;

        cfg_start = 1'b1; cfg_load_model = load_model;
        step();
        cfg_start = 1'b0; cfg_load_model = 1'b0;
        cyc = 1;

        while (acc < total_words && cyc < 4000) begin
            n_total++;
            if (in_ready !== 1'b1 || busy !== 1'b1 || start !== 1'b0) begin
                n_bad++;
                $display("FAIL %s/stream_flags cyc=%0d: in_ready=%b busy=%b start=%b want 1 1 0",
                         name, cyc, in_ready, busy, start);
            end
            n_total++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (load_trees !== 1'b1 || n_tree !== e.tree || n_node !== e.node || tree_nodes !== e.data) begin
                    n_bad++;
                    $display("FAIL %s/node_write cyc=%0d: load=%b tree=%0d node=%0d data=%h want 1 %0d %0d %h",
                             name, cyc, load_trees, n_tree, n_node, tree_nodes, e.tree, e.node, e.data);
                end
                if (gap_pct == 0 && last_pulse >= 0 && cyc - last_pulse != 2) begin
                    n_bad++;
                    $display("FAIL %s/load_spacing cyc=%0d: gap=%0d want 2", name, cyc, cyc - last_pulse);
                end
                pulses++;
                last_pulse = cyc;
            end else if (load_trees !== 1'b0) begin
                n_bad++;
                $display("FAIL %s/extra_load cyc=%0d: load_trees=%b want 0", name, cyc, load_trees);
            end
            if (acc == abort_at) begin
                in_valid = 1'b0;
                return;
            end

            drv = 1'b1;
            if (gap_pct > 0 && acc < node_words && (acc % 2) == 1 && $urandom_range(99) < gap_pct) begin
                drv = 1'b0;
            end
            if (drv) begin
                word = base + acc;
                in_data = word;
                if (acc < node_words) begin
                    if ((acc % 2) == 0) begin
                        lo_word = word;
                    end else begin
                        idx    = acc / 2;
                        e.tree = T_NT_W'(idx / T_NODES);
                        e.node = T_NN_W'(idx % T_NODES);
                        e.data = {word, lo_word};
                        exp_q.push_back(e);
                    end
                end else begin
                    feat_vec[(acc - node_words)*32 +: 32] = word;
                end
                acc++;
            end else begin
                in_data = $urandom();
            end
            in_valid = drv;
            step();
            cyc++;
        end
        in_valid = 1'b0;

        n_total++;
        if (acc < total_words) begin
            n_bad++;
            $display("FAIL %s/timeout: accepted %0d words want %0d", name, acc, total_words);
            return;
        end

        n_total++;
        if (start !== 1'b1 || in_ready !== 1'b0 || load_trees !== 1'b0) begin
            n_bad++;
            $display("FAIL %s/start_pulse cyc=%0d: start=%b in_ready=%b load=%b want 1 0 0",
                     name, cyc, start, in_ready, load_trees);
        end
        n_total++;
        if (pulses != (load_model ? T_TREES * T_NODES : 0)) begin
            n_bad++;
            $display("FAIL %s/load_count: got %0d want %0d", name, pulses, load_model ? T_TREES * T_NODES : 0);
        end
        n_total++;
        if (features !== feat_vec) begin
            n_bad++;
            $display("FAIL %s/features: got %h want %h", name, features, feat_vec);
        end

        for (int d = 0; d < done_delay; d++) begin
            if (poke && d == 0) cfg_start = 1'b1;
            step();
            cfg_start = 1'b0;
            n_total++;
            if (start !== 1'b0 || in_ready !== 1'b0 || result_valid !== 1'b0 || busy !== 1'b1 ||
                load_trees !== 1'b0 || features !== feat_vec) begin
                n_bad++;
                $display("FAIL %s/wait_hold d=%0d: start=%b in_ready=%b rv=%b busy=%b load=%b want 0 0 0 1 0, features %s",
                         name, d, start, in_ready, result_valid, busy, load_trees,
                         (features === feat_vec) ? "held" : "changed");
            end
        end

        done = 1'b1; prediction = pred;
        step();
        done = 1'b0; prediction = ~pred;
        n_total++;
        if (result_valid !== 1'b1 || result !== pred) begin
            n_bad++;
            $display("FAIL %s/result_capture: rv=%b result=%h want 1 %h", name, result_valid, result, pred);
        end

        for (int h = 0; h < hold; h++) begin
            if (poke && h == 1) begin
                done = 1'b1; prediction = 8'hEE;
            end
            step();
            done = 1'b0; prediction = ~pred;
            n_total++;
            if (result_valid !== 1'b1 || result !== pred || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL %s/result_hold h=%0d: rv=%b result=%h busy=%b want 1 %h 1",
                         name, h, result_valid, result, busy, pred);
            end
        end

        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        n_total++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || result !== pred) begin
            n_bad++;
            $display("FAIL %s/handshake: rv=%b busy=%b result=%h want 0 0 %h",
                     name, result_valid, busy, result, pred);
        end
        $display("job %s: words=%0d loads=%0d start_cyc=%0d result=%h", name, acc, pulses, total_words + 1, result);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_total++;
        if ({in_ready, load_trees, start, result_valid, busy} !== 5'b0 ||
            n_node !== '0 || n_tree !== '0 || tree_nodes !== '0 || features !== '0 || result !== '0) begin
            n_bad++;
            $display("FAIL reset_values: ctl=%b node=%0d tree=%0d nodes=%h feat=%h result=%h want all 0",
                     {in_ready, load_trees, start, result_valid, busy}, n_node, n_tree, tree_nodes, features, result);
        end
        rst_n = 1'b1;
        step();
        $display("reset: released");
    endtask

    task automatic test_full_load();
        run_job("full_load", 1'b1, 0, 3, 0, 8'h3C, 32'hA000_0000, 1'b0, -1);
    endtask

    task automatic test_features_only();
        run_job("features_only", 1'b0, 0, 2, 0, 8'h21, 32'h0000_0010, 1'b0, -1);
    endtask

    task automatic test_result_hold();
        run_job("result_hold", 1'b0, 0, 1, 5, 8'h07, 32'h0000_0100, 1'b0, -1);
    endtask

    task automatic test_valid_gaps();
        run_job("valid_gaps", 1'b1, 60, 2, 1, 8'h5D, 32'hA000_0000, 1'b0, -1);
    endtask

    task automatic test_ignore();
        run_job("ignore_poke", 1'b0, 0, 3, 3, 8'h44, 32'h0000_0200, 1'b1, -1);
        done = 1'b1; prediction = 8'h99;
        step();
        done = 1'b0; prediction = '0;
        step();
        n_total++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 8'h44 || in_ready !== 1'b0 || start !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_done: busy=%b rv=%b result=%h in_ready=%b start=%b want 0 0 44 0 0",
                     busy, result_valid, result, in_ready, start);
        end
        $display("ignore: idle done pulse, result=%h", result);
    endtask

    task automatic test_reset_midload();
        // 12 words = nodes (0,0)..(1,1) complete; the job is at node (1,2).
        run_job("midload", 1'b1, 0, 0, 0, 8'h00, 32'hB000_0000, 1'b0, 12);
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({in_ready, load_trees, start, result_valid, busy} !== 5'b0 ||
            n_node !== '0 || n_tree !== '0 || tree_nodes !== '0 || features !== '0 || result !== '0) begin
            n_bad++;
            $display("FAIL midload_reset: ctl=%b node=%0d tree=%0d nodes=%h feat=%h result=%h want all 0",
                     {in_ready, load_trees, start, result_valid, busy}, n_node, n_tree, tree_nodes, features, result);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        $display("midload: reset applied and released");
        run_job("after_reset", 1'b1, 0, 2, 1, 8'hC3, 32'hC000_0000, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_features_only();
        test_result_hold();
        test_valid_gaps();
        test_ignore();
        test_reset_midload();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
